// File: rtl/uncache_agent_if.sv
// uncache_agent_if: single-beat AXI channels between the uncache agent and the bus
interface uncache_agent_if #(parameter int ADDR_WD = 32, parameter int DATA_WD = 32);
  logic [3:0]         arid;
  logic [ADDR_WD-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;
  logic [DATA_WD-1:0] rdata_axi;
  logic               rvalid;
  logic               rready;
  logic [3:0]         awid;
  logic [ADDR_WD-1:0] awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;
  logic [DATA_WD-1:0] wdata;
  logic [3:0]         wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic               bvalid;
  logic               bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata_axi, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata_axi, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/uncache_agent.sv
// uncache_agent: services uncached core loads/stores as single-beat AXI transactions
module uncache_agent #(
  parameter logic [3:0] AXI_ID  = 4'd1,
  parameter int         ADDR_WD = 32,
  parameter int         DATA_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req_en,
  input  logic [3:0]         i_req_we,
  input  logic [ADDR_WD-1:0] i_req_addr,
  input  logic [DATA_WD-1:0] i_req_wdata,
  input  logic               i_hold,
  input  logic               i_flush,
  output logic [DATA_WD-1:0] o_rdata,
  output logic               o_stallreq_uncache,
  uncache_agent_if.master    axi
);
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE} state_t;
  state_t             r_state, w_next;
  logic [ADDR_WD-1:0] r_addr;
  logic [3:0]         r_we;
  logic [DATA_WD-1:0] r_wdata, r_rdata;
  logic               r_cancel, r_aw_done, r_w_done;
  logic               w_accept, w_busy, w_cancel, w_aw_fin, w_w_fin;
  assign w_accept = (r_state == IDLE) & i_req_en & ~i_flush;
  assign w_busy   = (r_state != IDLE) & (r_state != DONE);
  assign w_cancel = r_cancel | i_flush;
  assign w_aw_fin = r_aw_done | (axi.awvalid & axi.awready);
  assign w_w_fin  = r_w_done | (axi.wvalid & axi.wready);
  assign o_rdata            = r_rdata;
  assign o_stallreq_uncache = w_accept | w_busy;
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = r_state == RD_AR;
  assign axi.rready  = r_state == RD_R;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (r_state == WR_AW_W) & ~r_aw_done;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_we;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (r_state == WR_AW_W) & ~r_w_done;
  assign axi.bready  = r_state == WR_B;
  // next state: a cancelled transaction drains its handshakes, then skips DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (i_req_we == 4'd0) ? RD_AR : WR_AW_W;
      RD_AR:   if (axi.arready) w_next = RD_R;
      RD_R:    if (axi.rvalid) w_next = w_cancel ? IDLE : DONE;
      WR_AW_W: if (w_aw_fin & w_w_fin) w_next = WR_B;
      WR_B:    if (axi.bvalid) w_next = w_cancel ? IDLE : DONE;
      DONE:    if (~i_hold | i_flush) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, request latch, per-channel done flags, cancel flag and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_we      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cancel  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cancel <= (w_next == IDLE) ? 1'b0 : (w_busy & i_flush) ? 1'b1 : r_cancel;
      if (w_accept) begin
        r_addr    <= i_req_addr;
        r_we      <= i_req_we;
        r_wdata   <= i_req_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == WR_AW_W) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end
      if ((r_state == RD_R) & axi.rvalid & ~w_cancel) r_rdata <= axi.rdata_axi;
    end
  end
endmodule

// File: tb/tb_uncache_agent.sv
// tb_uncache_agent: table-driven cycle vectors plus backpressure and reset sequences
module tb_uncache_agent;
  logic        clk, reset, i_req_en, i_hold, i_flush, o_stallreq_uncache;
  logic [3:0]  i_req_we;
  logic [31:0] i_req_addr, i_req_wdata, o_rdata;
  int          n_chk, n_err, n_ar, n_aw, n_w;
  uncache_agent_if #(.ADDR_WD(32), .DATA_WD(32)) ax ();
  uncache_agent dut (
    .clk(clk), .reset(reset), .i_req_en(i_req_en), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_hold(i_hold),
    .i_flush(i_flush), .o_rdata(o_rdata), .o_stallreq_uncache(o_stallreq_uncache),
    .axi(ax)
  );
  typedef struct {
    logic        rst, en;
    logic [3:0]  we;
    logic [31:0] addr, wd;
    logic        hold, flush, arr, rv;
    logic [31:0] rd;
    logic        awr, wr, bv;
    logic [5:0]  ctl;
    logic [31:0] erd, eaddr;
    logic [3:0]  estrb;
    logic [31:0] ewd;
  } vec_t;
  vec_t tbl[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!reset && ax.arvalid && ax.arready) n_ar++;
    if (!reset && ax.awvalid && ax.awready) n_aw++;
    if (!reset && ax.wvalid && ax.wready) n_w++;
  end
  function automatic vec_t mk(input logic rst, en, input logic [3:0] we, input logic [31:0] addr, wd,
                              input logic hold, flush, arr, rv, input logic [31:0] rd,
                              input logic awr, wr, bv, input logic [5:0] ctl,
                              input logic [31:0] erd, eaddr, input logic [3:0] estrb, input logic [31:0] ewd);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.hold = hold; v.flush = flush;
    v.arr = arr; v.rv = rv; v.rd = rd; v.awr = awr; v.wr = wr; v.bv = bv; v.ctl = ctl;
    v.erd = erd; v.eaddr = eaddr; v.estrb = estrb; v.ewd = ewd;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; i_req_en = v.en; i_req_we = v.we; i_req_addr = v.addr; i_req_wdata = v.wd;
    i_hold = v.hold; i_flush = v.flush; ax.arready = v.arr; ax.rvalid = v.rv; ax.rdata_axi = v.rd;
    ax.awready = v.awr; ax.wready = v.wr; ax.bvalid = v.bv;
    #1;
    chk({tag, " ctl"}, 32'({ax.arvalid, ax.rready, ax.awvalid, ax.wvalid, ax.bready, o_stallreq_uncache}), 32'(v.ctl));
    chk({tag, " rdata"}, o_rdata, v.erd);
    if (v.ctl[5]) chk({tag, " araddr"}, ax.araddr, v.eaddr);
    if (v.ctl[3]) chk({tag, " awaddr"}, ax.awaddr, v.eaddr);
    if (v.ctl[2]) chk({tag, " wstrb"}, 32'(ax.wstrb), 32'(v.estrb));
    if (v.ctl[2]) chk({tag, " wdata"}, ax.wdata, v.ewd);
  endtask
  localparam logic [31:0] A0 = 32'hBFAF8000, A1 = 32'hBFAF8004, A2 = 32'hBFAF8008, A3 = 32'hBFAF800C;
  localparam logic [31:0] W0 = 32'h1FAF0010, W1 = 32'h1FAF0020, W2 = 32'h1FAF0030;
  localparam logic [31:0] D0 = 32'h1234ABCD, D1 = 32'h55AA55AA, D2 = 32'hFFFFFFFF, D3 = 32'h0A0B0C0D;
  initial begin
    int ar0;
    n_chk = 0; n_err = 0; n_ar = 0; n_aw = 0; n_w = 0;
    reset = 1'b1; i_req_en = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_hold = 0; i_flush = 0;
    ax.arready = 0; ax.rvalid = 0; ax.rdata_axi = 0; ax.awready = 0; ax.wready = 0; ax.bvalid = 0;
    repeat (2) @(posedge clk);
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000000, 0,0,0,0));
    tbl.push_back(mk(0,1,0,A0,0, 0,0,1,1,D0, 0,0,0, 6'b000001, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D0, 0,0,0, 6'b100001, 0,A0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D0, 0,0,0, 6'b010001, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D0, 0,0,0, 6'b000000, D0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D0, 0,0,0, 6'b000000, D0,0,0,0));
    tbl.push_back(mk(0,1,0,A1,0, 0,0,1,1,D1, 0,0,0, 6'b000001, D0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D1, 0,0,0, 6'b100001, D0,A1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D1, 0,0,0, 6'b010001, D0,0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,A1,0, 1,0,1,1,D1, 0,0,0, 6'b000000, D1,0,0,0));
    tbl.push_back(mk(0,1,0,A2,0, 0,0,0,0,0, 0,0,0, 6'b000000, D1,0,0,0));
    tbl.push_back(mk(0,1,0,A2,0, 0,0,0,0,0, 0,0,0, 6'b000001, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b100001, D1,A2,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0, 0,0,0, 6'b100001, D1,A2,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,0, 0,0,0, 6'b010001, D1,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b010001, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,D2, 0,0,0, 6'b010001, D1,0,0,0));
    tbl.push_back(mk(0,1,4'b0011,W0,32'hDEADBEEF, 0,0,0,0,0, 0,0,0, 6'b000001, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,0,0, 6'b001101, D1,W0,4'b0011,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,0,0, 6'b000101, D1,0,4'b0011,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0, 6'b000101, D1,0,4'b0011,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000011, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1, 6'b000011, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000000, D1,0,0,0));
    tbl.push_back(mk(0,1,4'hF,W1,32'h01020304, 0,0,0,0,0, 0,0,0, 6'b000001, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,0, 6'b001101, D1,W1,4'hF,32'h01020304));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1, 6'b000011, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000000, D1,0,0,0));
    tbl.push_back(mk(0,1,0,A0,0, 0,1,1,1,D0, 0,0,0, 6'b000000, D1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,D0, 0,0,0, 6'b000000, D1,0,0,0));
    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));
    chk("ar handshakes", n_ar, 3);
    chk("aw handshakes", n_aw, 2);
    chk("w handshakes", n_w, 2);
    chk("ar const", 32'({ax.arid, ax.arlen, ax.arsize, ax.arburst}), 32'({4'd1, 8'd0, 3'b010, 2'b01}));
    chk("aw const", 32'({ax.awid, ax.awlen, ax.awsize, ax.awburst, ax.wlast}), 32'({4'd1, 8'd0, 3'b010, 2'b01, 1'b1}));
    ar0 = n_ar;
    run(mk(0,1,0,A3,0, 0,0,0,0,0, 0,0,0, 6'b000001, D1,0,0,0), "bp req");
    for (int i = 0; i < 10; i++)
      run(mk(0,0,0,32'hFFFF0000,0, 0,0,0,0,0, 0,0,0, 6'b100001, D1,A3,0,0), $sformatf("bp wait%0d", i));
    run(mk(0,0,0,0,0, 0,0,1,0,0, 0,0,0, 6'b100001, D1,A3,0,0), "bp ar");
    run(mk(0,0,0,0,0, 0,0,0,1,D3, 0,0,0, 6'b010001, D1,0,0,0), "bp r");
    run(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000000, D3,0,0,0), "bp done");
    chk("bp one ar", n_ar - ar0, 1);
    run(mk(0,1,4'hF,W2,32'hCAFEF00D, 0,0,0,0,0, 0,0,0, 6'b000001, D3,0,0,0), "rst req");
    run(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,0, 6'b001101, D3,W2,4'hF,32'hCAFEF00D), "rst aw_w");
    run(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000011, D3,0,0,0), "rst wr_b");
    run(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000011, D3,0,0,0), "rst assert");
    run(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 6'b000000, 0,0,0,0), "rst after");
    run(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1, 6'b000000, 0,0,0,0), "rst idle");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
